ans_delay_timer_mc: RTL
=======================

ANS_DELAY_TIMER_MC -- requirements
Module: ans_delay_timer_mc

Interface
REQ-001 SHALL have parameter CH_NUM, default 4, number of independent delay-measure channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 16, counter width per channel (8..32).
REQ-003 SHALL have port clk  input  1  system clock, single clock domain.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port AcqSig_i  input  1  shared time-base tick, one clk wide, 0.1 ms period.
REQ-006 SHALL have port p_Start_i  input  CH_NUM  per-channel start pulse.
REQ-007 SHALL have port p_Hold_i  input  CH_NUM  per-channel hold (stop) pulse.
REQ-008 SHALL have port p_Clear_i  input  CH_NUM  per-channel clear pulse.
REQ-009 SHALL have port TimeOutSet_i  input  CH_NUM*CNT_W  per-channel limit, channel n at bits [n*CNT_W +: CNT_W]; 0 = limit disabled.
REQ-010 SHALL have port TimeCnt_o  output  CH_NUM*CNT_W  per-channel count, same packing.
REQ-011 SHALL have port Busy_o  output  CH_NUM  channel in RUN.
REQ-012 SHALL have port TimeOut_o  output  CH_NUM  level, channel expired on limit.
REQ-013 SHALL have port p_TimeOut_o  output  CH_NUM  one-clk pulse on entry to EXPIRED by limit.
REQ-014 SHALL have port Ovf_o  output  CH_NUM  level, count saturated at all-ones.
REQ-015 SHALL have port Irq_o  output  1  OR of TimeOut_o and Ovf_o, registered.

Function
REQ-016 Each channel SHALL run an FSM with states IDLE, RUN, HELD, EXPIRED.
REQ-017 Per-cycle priority SHALL be: clear > start > hold > tick.
REQ-018 Clear SHALL force IDLE, count 0, TimeOut_o/Ovf_o 0, from any state.
REQ-019 Start SHALL force RUN with count 0 and flags 0 from any state (restart), no tick counted that cycle.
REQ-020 Hold in RUN SHALL go HELD, count frozen; hold in other states SHALL be ignored.
REQ-021 In RUN with AcqSig_i=1 count SHALL increment by 1; no increment in IDLE/HELD/EXPIRED.
REQ-022 If limit nonzero and incremented value >= limit, next cycle SHALL show EXPIRED, TimeOut_o=1, p_TimeOut_o=1 for exactly one clk, count = new value.
REQ-023 If incremented value = 2^CNT_W-1, channel SHALL enter EXPIRED with Ovf_o=1, no wrap-around, no p_TimeOut_o unless REQ-022 also true.
REQ-024 Limit change during RUN SHALL take effect on the next tick; a limit already <= count SHALL expire on that tick.
REQ-025 Hold and tick in same cycle SHALL result in HELD without increment.
REQ-026 Busy_o SHALL be 1 only in RUN; all outputs SHALL be registered, latency one clk from input.
REQ-027 Channels SHALL be fully independent except shared AcqSig_i.
REQ-028 Irq_o SHALL follow OR of flags with one clk delay.

Reset
REQ-029 On rst=1 at clk edge all channels SHALL be IDLE, TimeCnt_o=0, Busy_o=0, TimeOut_o=0, p_TimeOut_o=0, Ovf_o=0, Irq_o=0.
REQ-030 rst asserted mid-RUN SHALL abort the measurement with no pulse output; rst SHALL override all inputs.

Configuration
REQ-031 With macro ANS_DELAY_TMR_EN defined, per-channel FSM state and TimeOut/Ovf flags SHALL be triplicated with 2-of-3 majority vote, voted value written back to all copies each clk.
REQ-032 Without ANS_DELAY_TMR_EN, single-copy registers SHALL be used; cycle behaviour SHALL be identical in both builds.

Verification
REQ-033 CH0 limit=5, start, 5 ticks -> cycle after 5th tick TimeCnt=5, TimeOut_o[0]=1, p_TimeOut_o[0] one clk, Irq_o=1 one clk later.
REQ-034 CH1 start, 3 ticks, hold, 4 ticks -> count stays 3, Busy_o[1]=0, no timeout.
REQ-035 CNT_W=8, limit=0, start, 300 ticks -> count 255, Ovf_o=1, p_TimeOut_o=0.
REQ-036 Clear+start+hold same cycle on CH2 in RUN -> IDLE, count 0; start+tick same cycle -> count 0 then increments from next tick.
REQ-037 CH0 and CH3 running, rst mid-count -> all outputs 0 next clk, no pulses.
REQ-038 TMR build: force one state copy flip in RUN -> count sequence unchanged vs non-TMR reference run.

Source files
------------

// File: rtl/ans_delay_timer_mc.sv
// ans_delay_timer_mc
// Multi-channel delay-measure timer. Each channel counts ticks of the shared
// time base AcqSig_i between a start pulse and a hold pulse. A channel expires
// when its count reaches a nonzero limit, or when the count saturates at all-ones.
//
// Ports
//   clk            system clock, single domain
//   rst            synchronous active-high reset
//   AcqSig_i       shared one-clk time-base tick
//   p_Start_i      per-channel start / restart pulse
//   p_Hold_i       per-channel hold pulse (effective in RUN only)
//   p_Clear_i      per-channel clear pulse
//   TimeOutSet_i   per-channel limit, channel n at [n*CNT_W +: CNT_W], 0 = no limit
//   TimeCnt_o      per-channel count, same packing
//   Busy_o         channel in RUN
//   TimeOut_o      channel expired on its limit (level)
//   p_TimeOut_o    one-clk pulse on expiry by limit
//   Ovf_o          count saturated at all-ones (level)
//   Irq_o          registered OR of all TimeOut_o / Ovf_o bits
//
// Build option
//   ANS_DELAY_TMR_EN  triplicates per-channel state and flags with 2-of-3
//                     majority vote; cycle behaviour matches the default build.
//
// state   | meaning
// --------+----------------------------------------------
// IDLE    | cleared or reset, count 0, not counting
// RUN     | counting AcqSig_i ticks
// HELD    | stopped by hold, count frozen
// EXPIRED | limit reached or count saturated, count frozen

module ans_delay_timer_mc #(
   parameter int CH_NUM = 4,
   parameter int CNT_W  = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      AcqSig_i,
   input  logic [CH_NUM-1:0]         p_Start_i,
   input  logic [CH_NUM-1:0]         p_Hold_i,
   input  logic [CH_NUM-1:0]         p_Clear_i,
   input  logic [CH_NUM*CNT_W-1:0]   TimeOutSet_i,
   output logic [CH_NUM*CNT_W-1:0]   TimeCnt_o,
   output logic [CH_NUM-1:0]         Busy_o,
   output logic [CH_NUM-1:0]         TimeOut_o,
   output logic [CH_NUM-1:0]         p_TimeOut_o,
   output logic [CH_NUM-1:0]         Ovf_o,
   output logic                      Irq_o
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RUN     = 2'd1;
   localparam logic [1:0] ST_HELD    = 2'd2;
   localparam logic [1:0] ST_EXPIRED = 2'd3;

   logic r_irq;

   for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
      logic [CNT_W-1:0] r_cnt;
      logic             r_pulse;

      logic [1:0]       w_state;
      logic             w_to;
      logic             w_ov;

      logic [1:0]       w_state_nx;
      logic             w_to_nx;
      logic             w_ov_nx;
      logic             w_pulse_nx;
      logic [CNT_W-1:0] w_cnt_nx;
      logic [CNT_W-1:0] w_inc;
      logic [CNT_W-1:0] w_lim;

      assign w_lim = TimeOutSet_i[g*CNT_W +: CNT_W];
      assign w_inc = r_cnt + 1'b1;

      always_comb begin
         w_state_nx = w_state;
         w_to_nx    = w_to;
         w_ov_nx    = w_ov;
         w_cnt_nx   = r_cnt;
         w_pulse_nx = 1'b0;
         if (p_Clear_i[g]) begin
            w_state_nx = ST_IDLE;
            w_to_nx    = 1'b0;
            w_ov_nx    = 1'b0;
            w_cnt_nx   = '0;
         end else if (p_Start_i[g]) begin
            w_state_nx = ST_RUN;
            w_to_nx    = 1'b0;
            w_ov_nx    = 1'b0;
            w_cnt_nx   = '0;
         end else if (w_state == ST_RUN) begin
            if (p_Hold_i[g]) begin
               w_state_nx = ST_HELD;
            end else if (AcqSig_i) begin
               w_cnt_nx = w_inc;
               // compare the incremented value so a limit lowered below the
               // current count still expires on the next tick
               if ((w_lim != '0) && (w_inc >= w_lim)) begin
                  w_state_nx = ST_EXPIRED;
                  w_to_nx    = 1'b1;
                  w_pulse_nx = 1'b1;
               end
               // RUN is always left at all-ones, so the increment never wraps
               if (w_inc == '1) begin
                  w_state_nx = ST_EXPIRED;
                  w_ov_nx    = 1'b1;
               end
            end
         end
      end

`ifdef ANS_DELAY_TMR_EN
      logic [1:0] r_state_a, r_state_b, r_state_c;
      logic       r_to_a, r_to_b, r_to_c;
      logic       r_ov_a, r_ov_b, r_ov_c;

      assign w_state = (r_state_a & r_state_b) | (r_state_a & r_state_c) | (r_state_b & r_state_c);
      assign w_to    = (r_to_a & r_to_b) | (r_to_a & r_to_c) | (r_to_b & r_to_c);
      assign w_ov    = (r_ov_a & r_ov_b) | (r_ov_a & r_ov_c) | (r_ov_b & r_ov_c);

      // next state is derived from the voted value, so a single upset copy is
      // overwritten on the following edge
      always_ff @(posedge clk) begin
         if (rst) begin
            r_state_a <= ST_IDLE;
            r_state_b <= ST_IDLE;
            r_state_c <= ST_IDLE;
            r_to_a    <= 1'b0;
            r_to_b    <= 1'b0;
            r_to_c    <= 1'b0;
            r_ov_a    <= 1'b0;
            r_ov_b    <= 1'b0;
            r_ov_c    <= 1'b0;
         end else begin
            r_state_a <= w_state_nx;
            r_state_b <= w_state_nx;
            r_state_c <= w_state_nx;
            r_to_a    <= w_to_nx;
            r_to_b    <= w_to_nx;
            r_to_c    <= w_to_nx;
            r_ov_a    <= w_ov_nx;
            r_ov_b    <= w_ov_nx;
            r_ov_c    <= w_ov_nx;
         end
      end
`else
      logic [1:0] r_state;
      logic       r_to;
      logic       r_ov;

      assign w_state = r_state;
      assign w_to    = r_to;
      assign w_ov    = r_ov;

      always_ff @(posedge clk) begin
         if (rst) begin
            r_state <= ST_IDLE;
            r_to    <= 1'b0;
            r_ov    <= 1'b0;
         end else begin
            r_state <= w_state_nx;
            r_to    <= w_to_nx;
            r_ov    <= w_ov_nx;
         end
      end
`endif

      always_ff @(posedge clk) begin
         if (rst) begin
            r_cnt   <= '0;
            r_pulse <= 1'b0;
         end else begin
            r_cnt   <= w_cnt_nx;
            r_pulse <= w_pulse_nx;
         end
      end

      assign TimeCnt_o[g*CNT_W +: CNT_W] = r_cnt;
      assign Busy_o[g]                   = (w_state == ST_RUN);
      assign TimeOut_o[g]                = w_to;
      assign Ovf_o[g]                    = w_ov;
      assign p_TimeOut_o[g]              = r_pulse;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= |(TimeOut_o | Ovf_o);
      end
   end

   assign Irq_o = r_irq;

endmodule
